// File: rtl/set_injector_core.sv
// set_injector_core
// Drives SET_SIZE registered stimulus channels that start from per-channel
// init values and are rewritten by alias-addressed commands. Also produces a
// clock-synchronous, delayed active-low release (rst_out_n) for the rest of
// the bench.
module set_injector_core #(
  parameter int SET_SIZE    = 5,
  parameter int SET_WIDTH   = 32,
  parameter int ALIAS_CHARS = 8,
  parameter int WAIT_RST    = 10,
  parameter int ALIAS_W     = 8 * ALIAS_CHARS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SET_SIZE*ALIAS_W-1:0]   set_alias,
  input  logic [SET_SIZE*SET_WIDTH-1:0] init_value,
  input  logic                          cmd_valid,
  input  logic                          cmd_init,
  input  logic [ALIAS_W-1:0]            cmd_alias,
  input  logic [SET_WIDTH-1:0]          cmd_data,
  output logic [SET_SIZE*SET_WIDTH-1:0] set_signals,
  output logic                          rst_out_n,
  output logic                          cmd_done,
  output logic                          cmd_err
);

  // The counter must be able to hold WAIT_RST-1 at minimum; one extra bit of
  // headroom keeps WAIT_RST=1 well defined.
  localparam int CNT_W = (WAIT_RST > 1) ? $clog2(WAIT_RST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_RST - 1);

  // Channel storage, release sequencing and status pulses.
  logic [SET_SIZE*SET_WIDTH-1:0] r_set_signals;
  logic [CNT_W-1:0]              r_rel_cnt;
  logic                          r_rst_out_n;
  logic                          r_cmd_done;
  logic                          r_cmd_err;

  // Alias decode results.
  logic [SET_SIZE-1:0] w_match;
  logic [SET_SIZE-1:0] w_sel;
  logic                w_found;
  logic                w_alias_nz;
  logic                w_accept;
  logic                w_reject;

  // Compare the command alias against every channel alias; a zero alias on
  // either side is treated as "unassigned" and never matches.
  always_comb begin
    w_match    = '0;
    w_alias_nz = (cmd_alias != '0);
    for (int i = 0; i < SET_SIZE; i++) begin
      w_match[i] = w_alias_nz &&
                   (set_alias[i*ALIAS_W +: ALIAS_W] == cmd_alias);
    end
  end

  // Reduce the match vector to a one-hot select; the lowest index wins when
  // several channels share an alias.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < SET_SIZE; i++) begin
      if (w_match[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  // Commands are only honoured once the release has been visible for a full
  // cycle, so the edge that raises rst_out_n still rejects.
  always_comb begin
    w_accept = cmd_valid && r_rst_out_n && w_found;
    w_reject = cmd_valid && !w_accept;
  end

  // Release counter: rst_out_n rises on the WAIT_RST-th edge after reset
  // deassertion and then holds until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rel_cnt   <= '0;
      r_rst_out_n <= 1'b0;
    end else if (!r_rst_out_n) begin
      r_rel_cnt <= r_rel_cnt + CNT_W'(1);
      if (r_rel_cnt == CNT_LAST) begin
        r_rst_out_n <= 1'b1;
      end
    end
  end

  // Channel update: reset and init commands take the live init_value slice;
  // data commands load cmd_data into the single selected channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_signals <= init_value;
    end else if (w_accept) begin
      for (int i = 0; i < SET_SIZE; i++) begin
        if (w_sel[i]) begin
          r_set_signals[i*SET_WIDTH +: SET_WIDTH] <=
            cmd_init ? init_value[i*SET_WIDTH +: SET_WIDTH] : cmd_data;
        end
      end
    end
  end

  // One-cycle status pulses; accept and reject are mutually exclusive by
  // construction, so done and err can never be high together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_done <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_done <= w_accept;
      r_cmd_err  <= w_reject;
    end
  end

  assign set_signals = r_set_signals;
  assign rst_out_n   = r_rst_out_n;
  assign cmd_done    = r_cmd_done;
  assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_set_injector_core.sv
// Directed bench for set_injector_core: release timing, a table of command
// vectors, and hand-written sequences for duplicate aliases, init_value
// isolation and mid-stream reset.
module tb_set_injector_core;

  localparam int SS = 5;
  localparam int SW = 32;
  localparam int AW = 64;

  localparam logic [SS*SW-1:0] INIT =
    160'hFFFFFFFF_33333333_55555555_22222222_AAAAAAAA;
  localparam logic [SS*AW-1:0] ALIASES =
    {64'h4934, 64'h4933, 64'h4932, 64'h4931, 64'h4930};

  logic              clk;
  logic              rst;
  logic [SS*AW-1:0]  set_alias;
  logic [SS*SW-1:0]  init_value;
  logic              cmd_valid;
  logic              cmd_init;
  logic [AW-1:0]     cmd_alias;
  logic [SW-1:0]     cmd_data;
  logic [SS*SW-1:0]  set_signals;
  logic              rst_out_n;
  logic              cmd_done;
  logic              cmd_err;

  int n_tests = 0;
  int n_fail  = 0;

  set_injector_core #(
    .SET_SIZE(SS), .SET_WIDTH(SW), .ALIAS_CHARS(8), .WAIT_RST(10)
  ) dut (
    .clk(clk), .rst(rst), .set_alias(set_alias), .init_value(init_value),
    .cmd_valid(cmd_valid), .cmd_init(cmd_init), .cmd_alias(cmd_alias),
    .cmd_data(cmd_data), .set_signals(set_signals), .rst_out_n(rst_out_n),
    .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             vld;
    logic             ini;
    logic [AW-1:0]    als;
    logic [SW-1:0]    dat;
    logic [SS*SW-1:0] sig;
    logic             done;
    logic             err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [SS*SW-1:0] act,
                     input logic [SS*SW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ini, input logic [AW-1:0] a,
                       input logic [SW-1:0] d);
    cmd_valid = v;
    cmd_init  = ini;
    cmd_alias = a;
    cmd_data  = d;
  endtask

  // Deassert reset mid-cycle and check rst_out_n over the next 10 edges;
  // commands offered on edges 5 and 10 must be rejected.
  task automatic release_check(input string tag);
    rst = 1'b0;
    chk({tag, "_rel0"}, {159'b0, rst_out_n}, 160'd0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 5 || k == 10) drive(1'b1, 1'b0, 64'h4932, 32'h0BAD0BAD);
      else                   drive(1'b0, 1'b0, 64'h0, 32'h0);
      tick();
      chk($sformatf("%s_rel%0d", tag, k), {159'b0, rst_out_n},
          {159'b0, (k == 10)});
      chk($sformatf("%s_err%0d", tag, k), {158'b0, cmd_done, cmd_err},
          {158'b0, 1'b0, (k == 5 || k == 10)});
    end
    drive(1'b0, 1'b0, 64'h0, 32'h0);
    chk({tag, "_sig"}, set_signals, INIT);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 64'h4932, 32'h12345678,
               160'hFFFFFFFF_33333333_12345678_22222222_AAAAAAAA, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 64'h4933, 32'hDEADBEEF,
               160'hFFFFFFFF_33333333_12345678_22222222_AAAAAAAA, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 64'h4939, 32'h11111111,
               160'hFFFFFFFF_33333333_12345678_22222222_AAAAAAAA, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 64'h4934, 32'h00000000,
               160'h00000000_33333333_12345678_22222222_AAAAAAAA, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 64'h4934, 32'h00000000,
               160'hFFFFFFFF_33333333_12345678_22222222_AAAAAAAA, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 64'h4930, 32'h00000001,
               160'hFFFFFFFF_33333333_12345678_22222222_00000001, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 64'h4930, 32'h00000002,
               160'hFFFFFFFF_33333333_12345678_22222222_00000002, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 64'h4930, 32'h00000003,
               160'hFFFFFFFF_33333333_12345678_22222222_00000003, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 64'h0000, 32'h44444444,
               160'hFFFFFFFF_33333333_12345678_22222222_00000003, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 64'h4932, 32'h99999999,
               160'hFFFFFFFF_33333333_55555555_22222222_00000003, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 64'h0000, 32'h00000000,
               160'hFFFFFFFF_33333333_55555555_22222222_00000003, 1'b0, 1'b0};

    rst        = 1'b1;
    set_alias  = ALIASES;
    init_value = INIT;
    drive(1'b0, 1'b0, 64'h0, 32'h0);

    // Power-on reset state.
    repeat (2) tick();
    chk("rst_sig", set_signals, INIT);
    chk("rst_flags", {157'b0, rst_out_n, cmd_done, cmd_err}, 160'd0);

    release_check("por");

    // Table of commands, one per edge, each checked after its edge.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].vld, vt[i].ini, vt[i].als, vt[i].dat);
      tick();
      chk($sformatf("vec%0d_sig", i), set_signals, vt[i].sig);
      chk($sformatf("vec%0d_st", i), {158'b0, cmd_done, cmd_err},
          {158'b0, vt[i].done, vt[i].err});
    end

    // init_value changes outside reset/init commands are ignored.
    init_value[1*SW +: SW] = 32'h77777777;
    tick();
    chk("iso_hold", set_signals,
        160'hFFFFFFFF_33333333_55555555_22222222_00000003);
    drive(1'b1, 1'b1, 64'h4931, 32'h0);
    tick();
    chk("iso_init", set_signals,
        160'hFFFFFFFF_33333333_55555555_77777777_00000003);
    drive(1'b0, 1'b0, 64'h0, 32'h0);
    init_value = INIT;

    // Duplicate alias "I1" on channels 1 and 3: only channel 1 updates.
    set_alias[3*AW +: AW] = 64'h4931;
    drive(1'b1, 1'b0, 64'h4931, 32'hCAFEBABE);
    tick();
    chk("dup_sig", set_signals,
        160'hFFFFFFFF_33333333_55555555_CAFEBABE_00000003);
    chk("dup_st", {158'b0, cmd_done, cmd_err}, {158'b0, 2'b10});
    set_alias = ALIASES;

    // Mid-stream reset with a done pulse in flight.
    drive(1'b1, 1'b0, 64'h4933, 32'h00000001);
    tick();
    chk("pre_rst_sig", set_signals,
        160'hFFFFFFFF_00000001_55555555_CAFEBABE_00000003);
    chk("pre_rst_done", {159'b0, cmd_done}, 160'd1);
    drive(1'b0, 1'b0, 64'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sig", set_signals, INIT);
    chk("mid_rst_flags", {157'b0, rst_out_n, cmd_done, cmd_err}, 160'd0);
    repeat (2) tick();
    release_check("mid");

    // First command after the restarted release is accepted.
    drive(1'b1, 1'b0, 64'h4933, 32'h00C0FFEE);
    tick();
    chk("post_sig", set_signals,
        160'hFFFFFFFF_00C0FFEE_55555555_22222222_AAAAAAAA);
    chk("post_st", {158'b0, cmd_done, cmd_err}, {158'b0, 2'b10});
    drive(1'b0, 1'b0, 64'h0, 32'h0);
    tick();
    chk("post_idle", {158'b0, cmd_done, cmd_err}, 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
